ext_pipe: RTL and testbench
===========================

// Module: ext_pipe
// PURPOSE
//  Registered, parametrised immediate extender for the pipelined datapath.
//  - Takes an IMM_W-bit immediate plus a 3-bit extend op and produces a DATA_W-bit operand.
//  - Uses valid/ready handshakes on both sides and a 2-entry skid buffer, so back-pressure
//    never creates a combinational ready path.
//  - Sits between decode and execute; flush is driven by the hazard unit.
// PARAMETERS
//  IMM_W   16  immediate width; legal range 1 <= IMM_W < DATA_W
//  DATA_W  32  output operand width
//  SHIFT   2   left-shift amount for SGNSH/ZERSH ops; IMM_W+SHIFT <= DATA_W
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  reset      in   1       asynchronous, active-high reset
//  flush      in   1       synchronous pipeline flush; discards all held entries
//  in_valid   in   1       imm/eop are valid this cycle
//  in_ready   out  1       block can accept an entry; driven only from a register
//  imm        in   IMM_W   raw immediate
//  eop        in   3       extend op, see BEHAVIOUR
//  out_valid  out  1       ext_out is valid
//  out_ready  in   1       consumer accepts ext_out
//  ext_out    out  DATA_W  extended operand
//  bad_op     out  1       sticky flag: an illegal eop was accepted
// BEHAVIOUR
//  Extend ops (eop). Let Z = DATA_W-IMM_W.
//   000 SGN   : {Z{imm[MSB]}, imm}
//   001 ZER   : {Z{1'b0}, imm}
//   010 HIGH  : {imm, Z{1'b0}}
//   011 SGNSH : SGN result << SHIFT (logical shift; dropped bits lost)
//   100 ZERSH : ZER result << SHIFT
//   101..111  : result is 0 and bad_op is set on acceptance
//  Handshakes
//   - accept  = in_valid & in_ready
//   - deliver = out_valid & out_ready
//   - Latency is 1 cycle: an entry accepted in cycle N appears on ext_out in cycle N+1.
//   - The extension is computed at accept time; imm/eop need not be held afterwards.
//  Storage: main register (drives ext_out) plus skid register. Occupancy states:
//   EMPTY : out_valid=0, in_ready=1
//           accept -> ONE
//   ONE   : out_valid=1, in_ready=1
//           accept & deliver  -> ONE (main reloads)
//           accept & !deliver -> TWO (entry goes to skid)
//           !accept & deliver -> EMPTY
//   TWO   : out_valid=1, in_ready=0
//           deliver -> ONE (skid moves to main)
//  - ext_out holds stable while out_valid & !out_ready.
//  - Delivery order matches acceptance order; no entry is dropped except by flush/reset.
//  - flush=1 forces the next state to EMPTY and ignores any same-cycle accept.
//    in_valid may still be high; the entry is lost and bad_op is not updated by it.
//  - flush does not clear bad_op; only reset clears it.
//  - Reset (async, any state, mid-transfer included): state EMPTY, out_valid=0,
//    in_ready=1, ext_out=0, bad_op=0. On reset release the block accepts on the first edge.
//  - A register does not change on cycles where it is not being loaded
//    (main when not reloading, skid when not filling).
// STRUCTURE
//  - ext_pkg: localparams for EOP_SGN/ZER/HIGH/SGNSH/ZERSH, the 3-bit eop width,
//    and the state encoding EMPTY/ONE/TWO.
//  - ext_core: purely combinational, parametrised on IMM_W/DATA_W/SHIFT;
//    (imm, eop) -> (value, illegal). Instantiated once, on the input side.
//  - ext_pipe: the occupancy FSM, main/skid registers and bad_op.
//  - Elaboration check: IMM_W < DATA_W and IMM_W+SHIFT <= DATA_W, else $error.
// TESTING (defaults IMM_W=16, DATA_W=32, SHIFT=2 unless stated)
//  1. Each op, out_ready=1, imm=16'h8001:
//     SGN->FFFF8001, ZER->00008001, HIGH->80010000, SGNSH->FFFE0004, ZERSH->00020004,
//     each exactly 1 cycle after accept.
//  2. Illegal op: eop=3'b110, imm=16'h1234 -> ext_out=0, bad_op=1 and stays 1 through
//     later legal ops and flushes until reset.
//  3. Back-pressure: out_ready=0, send A=0x0001, B=0x0002 (ZER)
//     -> in_ready=0 after B, ext_out holds 0x1. Raise out_ready
//     -> delivers 0x1 then 0x2, no loss, no duplication.
//  4. Streaming: in_valid=1 and out_ready=1 for 8 cycles with imm=0..7 (ZER)
//     -> 8 results in order at 1 per cycle; in_ready stays 1.
//  5. Flush in TWO with in_valid=1 on the same cycle -> next cycle out_valid=0,
//     in_ready=1, that input is discarded, and nothing is delivered afterwards.
//  6. Assert reset asynchronously between edges while in TWO -> outputs immediately 0 /
//     in_ready=1. Repeat test 1 with IMM_W=8, DATA_W=16, SHIFT=4, imm=8'h81:
//     SGN->FF81, SGNSH->F810.

Source files
------------

// File: rtl/ext_pkg.sv
// ============================================================================
// ext_pkg : extend-op codes and occupancy encoding shared by the extender
// Revision: 1.0
// ============================================================================
`default_nettype none

package ext_pkg;

  localparam int EOP_W = 3;

  localparam logic [EOP_W-1:0] EOP_SGN   = 3'b000;
  localparam logic [EOP_W-1:0] EOP_ZER   = 3'b001;
  localparam logic [EOP_W-1:0] EOP_HIGH  = 3'b010;
  localparam logic [EOP_W-1:0] EOP_SGNSH = 3'b011;
  localparam logic [EOP_W-1:0] EOP_ZERSH = 3'b100;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

`default_nettype wire

// File: rtl/ext_core.sv
// ============================================================================
// ext_core : combinational immediate extender, (imm, eop) -> (value, illegal)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [EOP_W-1:0]  eop,
  output logic [DATA_W-1:0] value,
  output logic              illegal
);

  localparam int Z = DATA_W - IMM_W;

  logic [DATA_W-1:0] sgn;
  logic [DATA_W-1:0] zer;

  assign sgn = {{Z{imm[IMM_W-1]}}, imm};
  assign zer = {{Z{1'b0}}, imm};

  always_comb begin
    value   = '0;
    illegal = 1'b0;
    case (eop)
      EOP_SGN:   value = sgn;
      EOP_ZER:   value = zer;
      EOP_HIGH:  value = {imm, {Z{1'b0}}};
      EOP_SGNSH: value = sgn << SHIFT;
      EOP_ZERSH: value = zer << SHIFT;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ext_pipe.sv
// ============================================================================
// ext_pipe : registered immediate extender with valid/ready and 2-entry skid
// Revision: 1.0
// ============================================================================
`default_nettype none

module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int SHIFT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [EOP_W-1:0]  eop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ext_out,
  output logic              bad_op
);

  if (IMM_W < 1 || IMM_W >= DATA_W || IMM_W + SHIFT > DATA_W) begin : g_param_check
    $error("ext_pipe: need 1 <= IMM_W < DATA_W and IMM_W+SHIFT <= DATA_W");
  end

  logic [DATA_W-1:0] value;
  logic              illegal;
  logic [DATA_W-1:0] skid;
  occ_t              state;
  logic              accept;
  logic              deliver;

  ext_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W),
    .SHIFT  (SHIFT)
  ) u_core (
    .imm     (imm),
    .eop     (eop),
    .value   (value),
    .illegal (illegal)
  );

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // ext_out is the main register itself; in_ready/out_valid are registered
  // alongside the state so no handshake path is combinational.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      ext_out   <= '0;
      skid      <= '0;
      bad_op    <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (accept && illegal) begin
        bad_op <= 1'b1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            ext_out   <= value;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            ext_out <= value;
          end else if (accept) begin
            skid     <= value;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (deliver) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (deliver) begin
            ext_out  <= skid;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ext_pipe.sv
// ============================================================================
// tb_ext_pipe : queue-model bench for ext_pipe (default and 8/16/4 configs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] imm = '0;
  logic [2:0]  eop = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ext_out;
  logic        bad_op;

  logic        flush8 = 1'b0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  imm8 = '0;
  logic [2:0]  eop8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b1;
  logic [15:0] ext_out8;
  logic        bad_op8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .SHIFT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .eop(eop), .out_valid(out_valid), .out_ready(out_ready),
    .ext_out(ext_out), .bad_op(bad_op)
  );

  ext_pipe #(.IMM_W(8), .DATA_W(16), .SHIFT(4)) dut8 (
    .clk(clk), .reset(reset), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .imm(imm8), .eop(eop8), .out_valid(out_valid8), .out_ready(out_ready8),
    .ext_out(ext_out8), .bad_op(bad_op8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from the op definitions, in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_ext(input int iw, input int dw, input int sh,
                                          input logic [31:0] d, input logic [2:0] op);
    logic [63:0] im, sg, r;
    im = {32'd0, d} & ((64'd1 << iw) - 64'd1);
    sg = ((im >> (iw - 1)) & 64'd1) != 0 ? im - (64'd1 << iw) : im;
    case (op)
      3'd0:    r = sg;
      3'd1:    r = im;
      3'd2:    r = im << (dw - iw);
      3'd3:    r = sg << sh;
      3'd4:    r = im << sh;
      default: r = 64'd0;
    endcase
    r = r & ((64'd1 << dw) - 64'd1);
    return r[31:0];
  endfunction

  // Behavioural model: an ordered queue of at most two pending results.
  logic [31:0] mq[$];
  bit          mbad = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mbad = 1'b0;
    end else begin
      bit acc, del;
      acc = in_valid && (mq.size() < 2);
      del = (mq.size() > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (del) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(ref_ext(16, 32, 2, {16'd0, imm}, eop));
          if (eop > 3'd4) mbad = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      check("model in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
      check("model bad_op", {31'd0, bad_op}, {31'd0, mbad});
      if (mq.size() > 0) check("model ext_out", ext_out, mq[0]);
    end
  end

  task automatic drive(input bit v, input logic [2:0] op, input logic [15:0] d,
                       input bit rdy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    eop       = op;
    imm       = d;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [2:0] op, input logic [15:0] exp);
    @(negedge clk);
    in_valid8 = 1'b1;
    eop8      = op;
    imm8      = 8'h81;
    @(posedge clk);
    #1;
    check("cfg8 literal", {16'd0, ext_out8}, {16'd0, exp});
    check("cfg8 model", {16'd0, ext_out8}, ref_ext(8, 16, 4, 32'h81, op));
  endtask

  logic [31:0] exp1 [5] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h00020004};
  logic [15:0] exp8 [5] = '{16'hFF81, 16'h0081, 16'h8100, 16'hF810, 16'h0810};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset ext_out", ext_out, 32'd0);
    check("reset bad_op", {31'd0, bad_op}, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 16'h8001, 1'b1, 1'b0);
      check("op literal", ext_out, exp1[i]);
      check("op valid", {31'd0, out_valid}, 32'd1);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    drive(1'b1, 3'b110, 16'h1234, 1'b1, 1'b0);
    check("illegal ext_out", ext_out, 32'd0);
    check("illegal bad_op", {31'd0, bad_op}, 32'd1);
    drive(1'b1, 3'd0, 16'h0005, 1'b1, 1'b0);
    check("bad_op after legal", {31'd0, bad_op}, 32'd1);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b1);
    check("bad_op after flush", {31'd0, bad_op}, 32'd1);

    drive(1'b1, 3'd1, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 16'h0002, 1'b0, 1'b0);
    check("bp in_ready", {31'd0, in_ready}, 32'd0);
    check("bp hold A", ext_out, 32'h1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    check("bp still A", ext_out, 32'h1);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    check("bp then B", ext_out, 32'h2);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    check("bp drained", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd1, 16'(i), 1'b1, 1'b0);
      check("stream data", ext_out, 32'(i));
      check("stream in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    drive(1'b1, 3'd1, 16'h0011, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 16'h0022, 1'b0, 1'b0);
    check("pre-flush full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 3'd1, 16'h0033, 1'b0, 1'b1);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    check("flush nothing after", {31'd0, out_valid}, 32'd0);

    drive(1'b1, 3'd1, 16'h0044, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 16'h0055, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("async out_valid", {31'd0, out_valid}, 32'd0);
    check("async in_ready", {31'd0, in_ready}, 32'd1);
    check("async ext_out", ext_out, 32'd0);
    check("async bad_op", {31'd0, bad_op}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 3'd1, 16'h0007, 1'b1, 1'b0);
    check("first edge accept", ext_out, 32'h7);
    drive(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) drive8(3'(i), exp8[i]);
    @(negedge clk);
    in_valid8 = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      imm       = 16'($urandom);
      eop       = ($urandom_range(0, 31) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      if (c == 1500) begin
        #3 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
